// File: rtl/sbox_seq_if.sv
// Handshake and S-box port bundle for sbox_seq.
// slave  : the sequencer (consumes start/din/sbox_data, drives the rest)
// master : the round datapath plus the shared S-box bank
interface sbox_seq_if #(
  parameter int NUM_BOX = 8,
  parameter int IN_W    = 6,
  parameter int OUT_W   = 4
);
  localparam int SEL_W = $clog2(NUM_BOX);

  logic                     start;
  logic                     abort;
  logic [NUM_BOX*IN_W-1:0]  din;
  logic                     busy;
  logic                     done;
  logic [NUM_BOX*OUT_W-1:0] dout;
  logic [SEL_W-1:0]         sbox_sel;
  logic [IN_W-1:0]          sbox_addr;
  logic [OUT_W-1:0]         sbox_data;

  modport master (
    output start, abort, din, sbox_data,
    input  busy, done, dout, sbox_sel, sbox_addr
  );

  modport slave (
    input  start, abort, din, sbox_data,
    output busy, done, dout, sbox_sel, sbox_addr
  );
endinterface

// File: rtl/sbox_seq.sv
// S-layer sequencer: walks one shared S-box lookup port across the
// NUM_BOX chunks of a keyed round value, one chunk per cycle, and
// assembles the packed result. Chunk/nibble 0 is the most significant.
module sbox_seq #(
  parameter int NUM_BOX = 8,
  parameter int IN_W    = 6,
  parameter int OUT_W   = 4
) (
  input  logic        clk,
  input  logic        rst,
  sbox_seq_if.slave   bus
);
  localparam int SEL_W = $clog2(NUM_BOX);
  localparam logic [SEL_W-1:0] LAST = SEL_W'(NUM_BOX - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]                         state;
  logic [SEL_W-1:0]                   idx;
  logic [NUM_BOX-1:0][IN_W-1:0]       din_q;
  logic [NUM_BOX-1:0][OUT_W-1:0]      acc;
  logic [NUM_BOX-1:0][OUT_W-1:0]      acc_next;
  logic [NUM_BOX-1:0][OUT_W-1:0]      dout_q;
  logic [SEL_W-1:0]                   rev;
  logic                               run;

  // Chunk k lives at packed slot NUM_BOX-1-k (MSB-first numbering).
  assign rev = LAST - idx;
  assign run = (state == S_RUN);

  // Current lookup result merged into the accumulator; also the value
  // committed to dout on the final lookup.
  always_comb begin
    acc_next      = acc;
    acc_next[rev] = bus.sbox_data;
  end

  // Outputs come only from registered state; sel/addr are forced to 0
  // outside RUN so the shared bank sees a quiet port.
  assign bus.busy      = run;
  assign bus.done      = (state == S_DONE);
  assign bus.dout      = dout_q;
  assign bus.sbox_sel  = run ? idx : '0;
  assign bus.sbox_addr = run ? din_q[rev] : '0;

  // Control FSM, lookup index, operand latch, accumulator and result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= S_IDLE;
      idx    <= '0;
      din_q  <= '0;
      acc    <= '0;
      dout_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          // start beats a simultaneous abort here: abort only acts in RUN.
          if (bus.start) begin
            din_q <= bus.din;
            idx   <= '0;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          if (bus.abort) begin
            // Partial result is dropped; dout keeps the last good value.
            idx   <= '0;
            state <= S_IDLE;
          end else begin
            acc <= acc_next;
            if (idx == LAST) begin
              dout_q <= acc_next;
              idx    <= '0;
              state  <= S_DONE;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        S_DONE: begin
          // Single-cycle completion pulse; any start here is dropped.
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
          idx   <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_sbox_seq.sv
// Self-checking bench for sbox_seq with a behavioural DES S-box bank.
module tb_sbox_seq;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  sbox_seq_if #(.NUM_BOX(8), .IN_W(6), .OUT_W(4)) bus ();

  sbox_seq #(.NUM_BOX(8), .IN_W(6), .OUT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // DES S1..S8, each 4 rows x 16 columns.
  localparam int SB [0:511] = '{
    14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7,
    0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
    4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0,
    15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13,
    15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10,
    3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
    0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15,
    13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9,
    10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8,
    13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
    13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7,
    1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12,
    7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15,
    13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
    10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4,
    3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14,
    2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9,
    14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
    4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14,
    11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3,
    12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11,
    10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
    9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6,
    4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13,
    4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1,
    13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
    1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2,
    6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12,
    13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7,
    1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
    7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8,
    2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11
  };

  function automatic logic [3:0] sbox_f(input int box, input logic [5:0] a);
    int row;
    int col;
    row = int'(a[5]) * 2 + int'(a[0]);
    col = int'(a[4:1]);
    return 4'(SB[box * 64 + row * 16 + col]);
  endfunction

  // Reference S-layer: nibble k = S(k+1) of chunk k, MSB first.
  function automatic logic [31:0] model(input logic [47:0] d);
    logic [31:0] r;
    r = '0;
    for (int k = 0; k < 8; k++) r = (r << 4) | 32'(sbox_f(k, d[47 - 6 * k -: 6]));
    return r;
  endfunction

  assign bus.sbox_data = sbox_f(int'(bus.sbox_sel), bus.sbox_addr);

  task automatic test_reset();
    rst = 1'b0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.din   = '0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({bus.busy, bus.done, bus.dout, bus.sbox_sel, bus.sbox_addr} !== 43'd0) begin
      n_fail++;
      $display("FAIL reset_hold: got busy=%b done=%b dout=%h sel=%0d addr=%h, want all 0",
               bus.busy, bus.done, bus.dout, bus.sbox_sel, bus.sbox_addr);
    end
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({bus.busy, bus.done, bus.dout, bus.sbox_sel, bus.sbox_addr} !== 43'd0) begin
      n_fail++;
      $display("FAIL reset_idle: got busy=%b done=%b dout=%h, want all 0",
               bus.busy, bus.done, bus.dout);
    end
  endtask

  // One full operation from IDLE; din is scrambled after the start edge
  // so any late resampling shows up in the result.
  task automatic test_single_op(input string name, input logic [47:0] d, input logic [31:0] exp);
    bus.din   = d;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.din   = ~d;
    for (int k = 0; k < 8; k++) begin
      n_checks++;
      if ({bus.busy, bus.done, bus.sbox_sel, bus.sbox_addr} !== {1'b1, 1'b0, 3'(k), d[47 - 6 * k -: 6]}) begin
        n_fail++;
        $display("FAIL %s_run%0d: got busy=%b done=%b sel=%0d addr=%h, want 1 0 %0d %h",
                 name, k, bus.busy, bus.done, bus.sbox_sel, bus.sbox_addr, k, d[47 - 6 * k -: 6]);
      end
      @(posedge clk); #1;
    end
    n_checks++;
    if ({bus.busy, bus.done, bus.sbox_sel, bus.sbox_addr, bus.dout} !== {1'b0, 1'b1, 3'd0, 6'd0, exp}) begin
      n_fail++;
      $display("FAIL %s_done: got busy=%b done=%b sel=%0d dout=%h, want 0 1 0 %h",
               name, bus.busy, bus.done, bus.sbox_sel, bus.dout, exp);
    end
    @(posedge clk); #1;
    n_checks++;
    if ({bus.busy, bus.done, bus.dout} !== {1'b0, 1'b0, exp}) begin
      n_fail++;
      $display("FAIL %s_after: got busy=%b done=%b dout=%h, want 0 0 %h",
               name, bus.busy, bus.done, bus.dout, exp);
    end
  endtask

  task automatic test_abort();
    test_single_op("abort_pre", 48'h0, 32'hEFA72C4D);
    bus.din   = 48'hFFFFFFFFFFFF;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.abort = 1'b0;
    n_checks++;
    if ({bus.busy, bus.done, bus.dout} !== {1'b0, 1'b0, 32'hEFA72C4D}) begin
      n_fail++;
      $display("FAIL abort_idle: got busy=%b done=%b dout=%h, want 0 0 efa72c4d",
               bus.busy, bus.done, bus.dout);
    end
    begin
      int dones;
      dones = 0;
      for (int i = 0; i < 10; i++) begin
        if (bus.done) dones++;
        @(posedge clk); #1;
      end
      n_checks++;
      if (dones !== 0 || bus.dout !== 32'hEFA72C4D) begin
        n_fail++;
        $display("FAIL abort_quiet: got %0d done pulses dout=%h, want 0 efa72c4d", dones, bus.dout);
      end
    end
    test_single_op("abort_post", 48'hFFFFFFFFFFFF, 32'hD9CE3DCB);
  endtask

  task automatic test_start_abort_idle();
    logic [47:0] d;
    int dones;
    d = {16'($urandom), $urandom};
    bus.din   = d;
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    n_checks++;
    if (bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL start_over_abort: got busy=%b, want 1", bus.busy);
    end
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.done) dones++;
      @(posedge clk); #1;
    end
    n_checks++;
    if (dones !== 1 || bus.dout !== model(d)) begin
      n_fail++;
      $display("FAIL start_over_abort_done: got %0d pulses dout=%h, want 1 %h", dones, bus.dout, model(d));
    end
  endtask

  task automatic test_back_to_back();
    int   times[$];
    logic prev_done;
    bus.din   = 48'h0;
    bus.start = 1'b1;
    prev_done = 1'b0;
    for (int s = 1; s <= 30; s++) begin
      @(posedge clk); #1;
      if (bus.done) begin
        times.push_back(s);
        n_checks++;
        if (bus.dout !== 32'hEFA72C4D) begin
          n_fail++;
          $display("FAIL b2b_dout: got %h, want efa72c4d", bus.dout);
        end
      end
      if (prev_done && bus.done) begin
        n_checks++;
        n_fail++;
        $display("FAIL b2b_width: done high two cycles in a row at sample %0d", s);
      end
      prev_done = bus.done;
    end
    bus.start = 1'b0;
    n_checks++;
    if (times.size() !== 3) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d done pulses, want 3", times.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (times[i] !== 9 + 10 * i) begin
          n_fail++;
          $display("FAIL b2b_time%0d: got sample %0d, want %0d", i, times[i], 9 + 10 * i);
        end
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    bus.din   = 48'hFFFFFFFFFFFF;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    n_checks++;
    if ({bus.busy, bus.done, bus.dout, bus.sbox_sel, bus.sbox_addr} !== 43'd0) begin
      n_fail++;
      $display("FAIL reset_mid: got busy=%b done=%b dout=%h sel=%0d addr=%h, want all 0",
               bus.busy, bus.done, bus.dout, bus.sbox_sel, bus.sbox_addr);
    end
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    begin
      logic [47:0] d;
      d = {16'($urandom), $urandom};
      test_single_op("reset_post", d, model(d));
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) begin
      logic [47:0] d;
      d = {16'($urandom), $urandom};
      test_single_op("rand", d, model(d));
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_single_op("zero", 48'h0, 32'hEFA72C4D);
    test_single_op("ones", 48'hFFFFFFFFFFFF, 32'hD9CE3DCB);
    test_single_op("s7_one", 48'h000000000040, 32'hEFA72CDD);
    test_abort();
    test_start_abort_idle();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
